// File: rtl/sipo_deframer.sv
// Serial-in, parallel-out deframer: collects MSB-first bits on bit_valid strobes
// into WIDTH-bit words and offers them on a registered valid/ready output.
module sipo_deframer #(
    parameter int WIDTH  = 8,
    parameter bit FRAMED = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serial_in,
    input  logic                     bit_valid,
    input  logic                     frame_start,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH):0]   bit_count,
    output logic                     overrun
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam state_t RESET_STATE = FRAMED ? IDLE : SHIFT;

    state_t           state_q, state_d;
    // Only the first WIDTH-1 bits need storing; the last bit is taken live from serial_in.
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] word;
    logic             word_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RESET_STATE;
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        word_done = 1'b0;
        word      = {shift_q, serial_in};

        if (bit_valid) begin
            if (FRAMED && frame_start) begin
                // A new frame marker silently restarts any partial word.
                shift_d = (WIDTH-1)'(serial_in);
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                shift_d = word[WIDTH-2:0];
                if (cnt_q == LAST_BIT) begin
                    cnt_d     = '0;
                    word_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        if (word_done) begin
            if (!valid_q || out_ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign bit_count = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: a framed and a free-running instance share one stimulus
// stream; a word-level reference model checks every cycle, table rows check key results.
module tb_sipo_deframer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         serial_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         out_ready = 1'b0;

    logic [W-1:0] data_f, data_u;
    logic         valid_f, valid_u;
    logic [3:0]   cnt_f, cnt_u;
    logic         ovr_f, ovr_u;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(W), .FRAMED(1'b1)) dut_f (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(data_f), .out_valid(valid_f),
        .out_ready(out_ready), .bit_count(cnt_f), .overrun(ovr_f)
    );

    sipo_deframer #(.WIDTH(W), .FRAMED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(data_u), .out_valid(valid_u),
        .out_ready(out_ready), .bit_count(cnt_u), .overrun(ovr_u)
    );

    // Reference model, index 0 = framed instance, 1 = free-running instance.
    bit          m_aligned [2];
    int          m_nbits   [2];
    int unsigned m_value   [2];
    int unsigned m_out     [2];
    bit          m_valid   [2];
    bit          m_ovr     [2];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_aligned[k] = (k == 1);
            m_nbits[k]   = 0;
            m_value[k]   = 0;
            m_out[k]     = 0;
            m_valid[k]   = 0;
            m_ovr[k]     = 0;
        end
    endtask

    task automatic model_edge(input bit sv, input bit bv, input bit fs, input bit rdy);
        for (int k = 0; k < 2; k++) begin
            bit          done = 0;
            int unsigned word = 0;
            if (bv) begin
                if (k == 0 && fs) begin
                    m_aligned[k] = 1;
                    m_nbits[k]   = 1;
                    m_value[k]   = sv;
                end else if (m_aligned[k]) begin
                    m_value[k] = m_value[k] * 2 + sv;
                    m_nbits[k]++;
                    if (m_nbits[k] == W) begin
                        done       = 1;
                        word       = m_value[k] % (1 << W);
                        m_nbits[k] = 0;
                        m_value[k] = 0;
                    end
                end
            end
            m_ovr[k] = done && m_valid[k] && !rdy;
            if (done && (!m_valid[k] || rdy)) begin
                m_out[k]   = word;
                m_valid[k] = 1;
            end else if (!done && m_valid[k] && rdy) begin
                m_valid[k] = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("f.data_out",  data_f,  m_out[0]);
        chk("f.out_valid", valid_f, m_valid[0]);
        chk("f.bit_count", cnt_f,   m_nbits[0]);
        chk("f.overrun",   ovr_f,   m_ovr[0]);
        chk("u.data_out",  data_u,  m_out[1]);
        chk("u.out_valid", valid_u, m_valid[1]);
        chk("u.bit_count", cnt_u,   m_nbits[1]);
        chk("u.overrun",   ovr_u,   m_ovr[1]);
    endtask

    task automatic step(input bit sv, input bit bv, input bit fs, input bit rdy);
        serial_in   = sv;
        bit_valid   = bv;
        frame_start = fs;
        out_ready   = rdy;
        @(posedge clk);
        #1;
        model_edge(sv, bv, fs, rdy);
        check_model();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".f.data_out"},  data_f,  0);
        chk({tag, ".f.out_valid"}, valid_f, 0);
        chk({tag, ".f.bit_count"}, cnt_f,   0);
        chk({tag, ".f.overrun"},   ovr_f,   0);
        chk({tag, ".u.data_out"},  data_u,  0);
        chk({tag, ".u.out_valid"}, valid_u, 0);
        chk({tag, ".u.bit_count"}, cnt_u,   0);
    endtask

    typedef struct {
        string        name;
        logic [W-1:0] word;
        int           nbits;
        bit           fs;
        bit           gap;
        bit           drain;
        bit           rdy;
        bit           last_rdy;
        logic [W-1:0] exp_data;
        bit           exp_valid;
        bit           exp_ovr;
    } vec_t;

    // Sends nbits of word MSB first; explicit bit_count checks apply to the framed instance.
    task automatic send_vec(input vec_t v);
        logic [W-1:0] w;
        w = v.word;
        if (v.drain) step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < v.nbits; i++) begin
            bit r;
            r = (i == W - 1) ? v.last_rdy : v.rdy;
            if (v.gap && i > 0) step(1'b0, 1'b0, 1'b0, r);
            step(w[W-1-i], 1'b1, v.fs && (i == 0), r);
            if (v.fs) chk({v.name, ".bit_count"}, cnt_f, (i + 1) % W);
        end
        chk({v.name, ".data_out"},  data_f,  v.exp_data);
        chk({v.name, ".out_valid"}, valid_f, v.exp_valid);
        chk({v.name, ".overrun"},   ovr_f,   v.exp_ovr);
        $display("row %-10s word=0x%02h data_out=0x%02h out_valid=%0b overrun=%0b",
                 v.name, v.word, data_f, valid_f, ovr_f);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"a5",      8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{"partial", 8'hFF, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{"3c",      8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[3] = '{"12gap",   8'h12, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
        vecs[4] = '{"34gap",   8'h34, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0};
        vecs[5] = '{"11stall", 8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[6] = '{"22drop",  8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
        vecs[7] = '{"55hold",  8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[8] = '{"aa_swap", 8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0};

        model_reset();
        #3;
        check_cleared("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Pre-frame garbage: the framed instance must stay idle.
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b1);
            chk("garbage.bit_count", cnt_f, 0);
        end

        for (int r = 0; r < 9; r++) begin
            send_vec(vecs[r]);
            if (r == 0) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                chk("a5.accepted", valid_f, 0);
            end
            if (r == 6) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk("ovr.one_cycle", ovr_f, 0);
                chk("stall.data", data_f, 8'h11);
                step(1'b0, 1'b0, 1'b0, 1'b1);
                chk("stall.accept", valid_f, 0);
            end
        end

        // Asynchronous reset in the middle of a word with a word pending.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_cleared("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Free-running instance assembles 0xF0 without any frame marker.
        for (int i = 0; i < W; i++) step(i < 4, 1'b1, 1'b0, 1'b0);
        chk("f0.u.data_out",  data_u,  8'hF0);
        chk("f0.u.out_valid", valid_u, 1);
        chk("f0.f.out_valid", valid_f, 0);
        $display("row %-10s word=0x%02h data_out=0x%02h out_valid=%0b", "f0_free", 8'hF0, data_u, valid_u);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(1)), $urandom_range(3) != 0,
                 $urandom_range(15) == 0, $urandom_range(2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
